// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Memory-stage data-memory block. It accepts one load or store per cycle,
// steers store data and byte enables into a synchronous BRAM, and returns
// aligned, sign- or zero-extended load data one cycle after the request.
// Misaligned and out-of-range requests are flagged so the core can trap.
//
// Ports:
//   clk           core clock, all state changes on the rising edge
//   reset         synchronous, active-high reset
//   mem_en        load/store request valid this cycle
//   mem_write     1 = store, 0 = load
//   byte_access   00 word, 01 byte, 10 halfword, 11 treated as word
//   byte_src      000 lbu, 001 lhu, 010 lb, 011 lh, 100 lw, 101-111 raw word
//   addr          byte address
//   wdata         store data, right-aligned
//   hold          pipeline stall; freezes every register in this block
//   rdata         extracted load result
//   rdata_valid   rdata holds a completed load
//   misalign      previous accepted request was misaligned
//   access_fault  previous accepted request was out of range
//   fault_addr    byte address of the most recent faulting request
module dmem_access_unit #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_write,
    input  logic [1:0]  byte_access,
    input  logic [2:0]  byte_src,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        hold,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        access_fault,
    output logic [31:0] fault_addr
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    // Data storage and its registered read port
    logic [31:0] mem [DEPTH];
    logic [31:0] mem_q_reg;

    // Load context captured alongside the BRAM read
    logic [1:0]  offset_reg;
    logic [2:0]  bsrc_reg;

    // Output state
    logic        rdata_valid_reg;
    logic        misalign_reg;
    logic        access_fault_reg;
    logic [31:0] fault_addr_reg;
    // Value shown on rdata whenever no fresh load result is present
    logic [31:0] rdata_last_reg;

    // Request decode
    logic          accept;
    logic          is_word;
    logic          is_half;
    logic          mis_now;
    logic          oor_now;
    logic          fault_now;
    logic [AW-1:0] word_idx;
    logic [31:0]   wr_lanes;
    logic [3:0]    wr_be;

    assign accept    = mem_en && !hold && !reset;
    assign is_word   = (byte_access == 2'b00) || (byte_access == 2'b11);
    assign is_half   = (byte_access == 2'b10);
    assign mis_now   = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign oor_now   = (addr[31:2] >= DEPTH_W);
    assign fault_now = mis_now || oor_now;
    assign word_idx  = addr[AW+1:2];

    // Store lane replication and byte enables, one slice per byte lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_lanes[gi*8 +: 8] = (byte_access == 2'b01) ? wdata[7:0] :
                                         (byte_access == 2'b10) ? wdata[(gi % 2)*8 +: 8] :
                                                                  wdata[gi*8 +: 8];
            assign wr_be[gi] = (byte_access == 2'b01) ? (addr[1:0] == 2'(gi)) :
                               (byte_access == 2'b10) ? (addr[1] == 1'(gi / 2)) :
                                                        1'b1;
        end
    endgenerate

    // BRAM: byte-enabled write, read-first registered read. Faulting
    // requests never touch the array, so word_idx is always in range here.
    always_ff @(posedge clk) begin
        if (accept && mem_write && !fault_now) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wr_lanes[b*8 +: 8];
                end
            end
        end
        if (accept && !mem_write && !fault_now) begin
            mem_q_reg <= mem[word_idx];
        end
    end

    // Load-result extraction from the BRAM output and captured offset
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] rdata_ext;

    always_comb begin
        sel_byte = mem_q_reg[7:0];
        case (offset_reg)
            2'd0:    sel_byte = mem_q_reg[7:0];
            2'd1:    sel_byte = mem_q_reg[15:8];
            2'd2:    sel_byte = mem_q_reg[23:16];
            default: sel_byte = mem_q_reg[31:24];
        endcase
        sel_half = offset_reg[1] ? mem_q_reg[31:16] : mem_q_reg[15:0];
        case (bsrc_reg)
            3'b000:  rdata_ext = {24'b0, sel_byte};
            3'b001:  rdata_ext = {16'b0, sel_half};
            3'b010:  rdata_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b011:  rdata_ext = {{16{sel_half[15]}}, sel_half};
            default: rdata_ext = mem_q_reg;
        endcase
    end

    // Control and status registers. Inside the !hold branch mem_en is
    // equivalent to an accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_valid_reg  <= 1'b0;
            misalign_reg     <= 1'b0;
            access_fault_reg <= 1'b0;
            fault_addr_reg   <= 32'h0;
            offset_reg       <= 2'b00;
            bsrc_reg         <= 3'b000;
            rdata_last_reg   <= 32'h0;
        end else if (!hold) begin
            rdata_valid_reg  <= mem_en && !mem_write && !fault_now;
            misalign_reg     <= mem_en && mis_now;
            // Misalignment wins when both checks fire
            access_fault_reg <= mem_en && !mis_now && oor_now;
            if (mem_en && fault_now) begin
                fault_addr_reg <= addr;
            end
            if (mem_en && !mem_write && !fault_now) begin
                offset_reg <= addr[1:0];
                bsrc_reg   <= byte_src;
            end
            // A fault clears rdata; otherwise remember the result being
            // shown so it persists through idle and store cycles.
            if (mem_en && fault_now) begin
                rdata_last_reg <= 32'h0;
            end else if (rdata_valid_reg) begin
                rdata_last_reg <= rdata_ext;
            end
        end
    end

    assign rdata        = rdata_valid_reg ? rdata_ext : rdata_last_reg;
    assign rdata_valid  = rdata_valid_reg;
    assign misalign     = misalign_reg;
    assign access_fault = access_fault_reg;
    assign fault_addr   = fault_addr_reg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a table of single-cycle requests
// with hand-computed results, then hold and reset sequences.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        mem_write;
    logic [1:0]  byte_access;
    logic [2:0]  byte_src;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        access_fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    dmem_access_unit #(.DEPTH(1024), .AW(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_en       (mem_en),
        .mem_write    (mem_write),
        .byte_access  (byte_access),
        .byte_src     (byte_src),
        .addr         (addr),
        .wdata        (wdata),
        .hold         (hold),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .misalign     (misalign),
        .access_fault (access_fault),
        .fault_addr   (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  ba;
        logic [2:0]  bs;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] e_rd;
        logic        e_v;
        logic        e_m;
        logic        e_f;
        logic [31:0] e_fa;
    } vec_t;

    vec_t vq[$];

    // Drive one cycle of inputs, then sample #1 after the rising edge
    task automatic step(input logic rst, input logic hl, input logic en, input logic wr,
                        input logic [1:0] ba, input logic [2:0] bs,
                        input logic [31:0] a, input logic [31:0] wd);
        reset = rst; hold = hl; mem_en = en; mem_write = wr;
        byte_access = ba; byte_src = bs; addr = a; wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] e_rd, input logic e_v,
                         input logic e_m, input logic e_f, input logic [31:0] e_fa);
        checks += 5;
        if (rdata !== e_rd) begin
            errors++;
            $display("FAIL %s rdata got %h want %h", name, rdata, e_rd);
        end
        if (rdata_valid !== e_v) begin
            errors++;
            $display("FAIL %s rdata_valid got %b want %b", name, rdata_valid, e_v);
        end
        if (misalign !== e_m) begin
            errors++;
            $display("FAIL %s misalign got %b want %b", name, misalign, e_m);
        end
        if (access_fault !== e_f) begin
            errors++;
            $display("FAIL %s access_fault got %b want %b", name, access_fault, e_f);
        end
        if (fault_addr !== e_fa) begin
            errors++;
            $display("FAIL %s fault_addr got %h want %h", name, fault_addr, e_fa);
        end
        $display("%s: rdata=%h valid=%b mis=%b flt=%b faddr=%h", name, rdata,
                 rdata_valid, misalign, access_fault, fault_addr);
    endtask

    initial begin
        // en wr ba bs addr wdata | rdata valid mis flt faddr
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h00, 32'h0BADC0DE, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h20, 32'h80FF7F01, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b01, 3'd2, 32'h23, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b01, 3'd0, 32'h23, 32'h0,        32'h00000080, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b01, 3'd2, 32'h22, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b10, 3'd3, 32'h22, 32'h0,        32'hFFFF80FF, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b10, 3'd1, 32'h20, 32'h0,        32'h00007F01, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd7, 32'h20, 32'h0,        32'h80FF7F01, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h40, 32'h11223344, 32'h80FF7F01, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b01, 3'd4, 32'h41, 32'h123456AA, 32'h80FF7F01, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h40, 32'h0,        32'h1122AA44, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b10, 3'd4, 32'h42, 32'h5555BEEF, 32'h1122AA44, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h40, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h44, 32'hCAFEF00D, 32'hBEEFAA44, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h50, 32'h55AA55AA, 32'hBEEFAA44, 1'b0, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h42, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h42});
        vq.push_back('{1'b0, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h42});
        vq.push_back('{1'b1, 1'b1, 2'b10, 3'd4, 32'h45, 32'h00001234, 32'h0,        1'b0, 1'b1, 1'b0, 32'h45});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h44, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'h45});
        vq.push_back('{1'b1, 1'b1, 2'b11, 3'd4, 32'h61, 32'hDEADDEAD, 32'h0,        1'b0, 1'b1, 1'b0, 32'h61});
        vq.push_back('{1'b1, 1'b1, 2'b00, 3'd4, 32'h1000, 32'h12345678, 32'h0,      1'b0, 1'b0, 1'b1, 32'h1000});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h00, 32'h0,        32'h0BADC0DE, 1'b1, 1'b0, 1'b0, 32'h1000});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h1002, 32'h0,      32'h0,        1'b0, 1'b1, 1'b0, 32'h1002});
        vq.push_back('{1'b1, 1'b0, 2'b01, 3'd0, 32'h1000, 32'h0,      32'h0,        1'b0, 1'b0, 1'b1, 32'h1000});
        vq.push_back('{1'b0, 1'b1, 2'b00, 3'd4, 32'h20, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h1000});
        vq.push_back('{1'b1, 1'b0, 2'b01, 3'd2, 32'h21, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1'b0, 32'h1000});
        vq.push_back('{1'b1, 1'b0, 2'b00, 3'd4, 32'h40, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0, 1'b0, 32'h1000});

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0);
        check("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            step(1'b0, 1'b0, vq[i].en, vq[i].wr, vq[i].ba, vq[i].bs, vq[i].a, vq[i].wd);
            check($sformatf("vec%0d", i), vq[i].e_rd, vq[i].e_v, vq[i].e_m, vq[i].e_f, vq[i].e_fa);
        end

        // Hold: result frozen, store under hold ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0);
        check("hold_lw", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'd4, 32'h10, 32'h0);
            check($sformatf("hold_frz%0d", i), 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h1000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0);
        check("hold_idle", 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h1000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0);
        check("hold_nowr", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h1000);

        // Hold extends a fault flag
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd4, 32'h42, 32'h0);
        check("hfault", 32'h0, 1'b0, 1'b1, 1'b0, 32'h42);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd4, 32'h0, 32'h0);
            check($sformatf("hfault_ext%0d", i), 32'h0, 1'b0, 1'b1, 1'b0, 32'h42);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'd4, 32'h0, 32'h0);
        check("hfault_clr", 32'h0, 1'b0, 1'b0, 1'b0, 32'h42);

        // Reset mid-operation, with hold also asserted
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd4, 32'h10, 32'h0);
        check("pre_rst", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h42);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'd4, 32'h50, 32'h12345678);
        check("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd4, 32'h50, 32'h0);
        check("post_rst", 32'h55AA55AA, 1'b1, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
